// File: rtl/aes_spi_master.sv
// Serial master feeding key+block to the AES decrypt unit over MOSI/cs_enc, then collecting the result on MISO.
// Optional WAIT timeout guarded by macro AES_SPI_TIMEOUT_EN; start is ignored while busy (no queueing).
module aes_spi_master #(
  parameter int nk             = 8,
  parameter int nb             = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*nk-1:0]  key_in,
  input  logic [32*nb-1:0]  data_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [32*nb-1:0]  data_out,
  output logic              mosi,
  output logic              cs_enc,
  input  logic              miso,
  input  logic              data_done
);

  localparam int KW = 32 * nk;
  localparam int BW = 32 * nb;
  localparam int SW = KW + BW;
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  tx_sreg;
  logic [BW-1:0]  rx_sreg;
  logic [CW-1:0]  cnt;
  logic           send_last;
  logic           recv_last;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
    $fatal(1, "TIMEOUT_CYCLES must be at least 2");
  end

  assign send_last = (cnt == CW'(SW - 1));
  assign recv_last = (cnt == CW'(BW - 1));

  // Handshake outputs decode straight from state so an async reset clears them at once.
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign cs_enc = (state == SEND);
  assign mosi   = (state == SEND) & tx_sreg[SW-1];

`ifdef AES_SPI_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt;
  logic           timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      error <= 1'b0;
    end else begin
      tcnt  <= (state == WAIT && !timeout) ? tcnt + 1'b1 : '0;
      error <= timeout;
    end
  end
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
`ifdef AES_SPI_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: if (send_last) state_nxt = WAIT;
      WAIT: begin
        if (data_done) begin
          state_nxt = RECV;
        end
`ifdef AES_SPI_TIMEOUT_EN
        else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
`endif
      end
      RECV: if (recv_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_sreg  <= '0;
      rx_sreg  <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sreg <= {key_in, data_in};
            cnt     <= '0;
          end
        end
        SEND: begin
          tx_sreg <= tx_sreg << 1;
          cnt     <= cnt + 1'b1;
        end
        WAIT: cnt <= '0;
        RECV: begin
          rx_sreg <= {rx_sreg[BW-2:0], miso};
          cnt     <= cnt + 1'b1;
          // Load on the final bit so data_out is already valid while done is high.
          if (recv_last) data_out <= {rx_sreg[BW-2:0], miso};
        end
        default: ;
      endcase
    end
  end

endmodule
